cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the 17-bit single-bus processor. Owns the PC and instruction register (IR) and fetches from instruction memory over a req/ack handshake. Presents IR to the instruction decoder, then gates the decoder's write strobes (RW, MW) with a one-cycle execute pulse. Computes the next PC from the decoder's BS/PS outputs and the function unit's zero flag.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/cpu_sequencer_if.sv | 26 ++
 rtl/pc_next_unit.sv | 43 ++++
 rtl/cpu_sequencer.sv | 107 ++++++++++
 tb/tb_cpu_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 17-bit single-bus processor control path:
// width defaults, opcodes, branch-select encodings and sequencer states.
package cpu_pkg;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned INST_W = 17;
  localparam int unsigned OFF_W  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned OPC_W  = 5;

  // Opcode field lives in IR[INST_W-1:INST_W-5].
  localparam logic [OPC_W-1:0] OP_NOP  = 5'd0;
  localparam logic [OPC_W-1:0] OP_MOVA = 5'd1;
  localparam logic [OPC_W-1:0] OP_INC  = 5'd2;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OPC_W-1:0] OP_DEC  = 5'd5;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd6;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd7;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'd8;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd9;
  localparam logic [OPC_W-1:0] OP_MOVB = 5'd10;
  localparam logic [OPC_W-1:0] OP_LD   = 5'd11;
  localparam logic [OPC_W-1:0] OP_ST   = 5'd12;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'd13;
  localparam logic [OPC_W-1:0] OP_ADI  = 5'd14;
  localparam logic [OPC_W-1:0] OP_BRZ  = 5'd15;
  localparam logic [OPC_W-1:0] OP_BRN  = 5'd16;
  localparam logic [OPC_W-1:0] OP_JMP  = 5'd17;
  localparam logic [OPC_W-1:0] OP_JML  = 5'd18;

  // Branch select from the decoder.
  localparam logic [1:0] BS_INC  = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_REG  = 2'b10;
  localparam logic [1:0] BS_JMP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC
  } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction-memory fetch handshake: sequencer is master, memory is slave.
interface cpu_sequencer_if #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned INST_W = 17
);

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_next_unit.sv
// Combinational next-PC and link-address computation, all modulo 2^PC_W.
module pc_next_unit #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OFF_W = 8
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [1:0]       bs,
  input  logic             ps,
  input  logic             zero,
  input  logic [OFF_W-1:0] off,
  input  logic [PC_W-1:0]  reg_a,
  output logic [PC_W-1:0]  next_pc,
  output logic [PC_W-1:0]  link_pc
);

  import cpu_pkg::*;

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] rel_pc;

  // Sign-extend (or truncate) the offset to PC width, then form both targets.
  always_comb begin
    seq_pc  = pc + PC_W'(1);
    off_ext = PC_W'({{PC_W{off[OFF_W-1]}}, off});
    rel_pc  = seq_pc + off_ext;
  end

  // Select the next PC from branch select and the zero/polarity condition.
  always_comb begin
    next_pc = seq_pc;
    case (bs)
      BS_INC:  next_pc = seq_pc;
      BS_COND: next_pc = (zero ^ ps) ? rel_pc : seq_pc;
      BS_REG:  next_pc = reg_a;
      BS_JMP:  next_pc = rel_pc;
      default: next_pc = seq_pc;
    endcase
  end

  assign link_pc = seq_pc;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer: owns PC and IR, fetches over a
// req/ack handshake and issues a one-cycle commit pulse per instruction.
module cpu_sequencer #(
  parameter int unsigned PC_W   = cpu_pkg::PC_W,
  parameter int unsigned INST_W = cpu_pkg::INST_W,
  parameter int unsigned OFF_W  = cpu_pkg::OFF_W,
  parameter int unsigned CNT_W  = cpu_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  cpu_sequencer_if.master    imem,
  output logic [INST_W-1:0]  ir,
  input  logic [1:0]         bs,
  input  logic               ps,
  input  logic               zero,
  input  logic [PC_W-1:0]    reg_a,
  input  logic               dmem_busy,
  output logic               exec_en,
  output logic [PC_W-1:0]    link_pc,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic [CNT_W-1:0]   retired
);

  import cpu_pkg::*;

  seq_state_t        state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_d;
  logic [INST_W-1:0] ir_q;
  logic [CNT_W-1:0]  retired_q;
  logic [CNT_W-1:0]  retired_d;

  pc_next_unit #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_pc_next (
    .pc      (pc_q),
    .bs      (bs),
    .ps      (ps),
    .zero    (zero),
    .off     (ir_q[OFF_W-1:0]),
    .reg_a   (reg_a),
    .next_pc (pc_d),
    .link_pc (link_pc)
  );

  // Saturating increment of the retired-instruction count.
  always_comb begin
    retired_d = retired_q;
    if (retired_q != '1) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Sequencer state, PC, IR and retired count; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (imem.imem_ack) begin
            ir_q    <= imem.imem_rdata;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (!dmem_busy) begin
            pc_q      <= pc_d;
            retired_q <= retired_d;
            state_q   <= run ? ST_FETCH : ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Request and busy decode straight from the state register; the commit
  // pulse must also see dmem_busy in the same cycle to honour EXEC stalls.
  always_comb begin
    imem.imem_req  = (state_q == ST_FETCH);
    imem.imem_addr = pc_q;
    exec_en        = (state_q == ST_EXEC) && !dmem_busy;
    busy           = (state_q != ST_IDLE);
  end

  assign ir      = ir_q;
  assign pc      = pc_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a driver plays instruction memory and
// decoder, pushing the expected PC/link/next-PC per instruction; a monitor
// pops and compares on every commit pulse.
module tb_cpu_sequencer;

  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [1:0]  bs;
  logic        ps;
  logic        zero;
  logic [7:0]  reg_a;
  logic        dmem_busy;

  logic [16:0] ir;
  logic        exec_en;
  logic [7:0]  link_pc;
  logic [7:0]  pc;
  logic        busy;
  logic [15:0] retired;

  logic [16:0] ir_s;
  logic        exec_en_s;
  logic [7:0]  link_pc_s;
  logic [7:0]  pc_s;
  logic        busy_s;
  logic [2:0]  retired_s;

  cpu_sequencer_if #(.PC_W(8), .INST_W(17)) bus ();
  cpu_sequencer_if #(.PC_W(8), .INST_W(17)) bus_s ();

  assign bus_s.imem_ack   = bus.imem_ack;
  assign bus_s.imem_rdata = bus.imem_rdata;

  cpu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .imem      (bus),
    .ir        (ir),
    .bs        (bs),
    .ps        (ps),
    .zero      (zero),
    .reg_a     (reg_a),
    .dmem_busy (dmem_busy),
    .exec_en   (exec_en),
    .link_pc   (link_pc),
    .pc        (pc),
    .busy      (busy),
    .retired   (retired)
  );

  // Narrow-counter copy in lockstep, so saturation is reachable quickly.
  cpu_sequencer #(.CNT_W(3)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .imem      (bus_s),
    .ir        (ir_s),
    .bs        (bs),
    .ps        (ps),
    .zero      (zero),
    .reg_a     (reg_a),
    .dmem_busy (dmem_busy),
    .exec_en   (exec_en_s),
    .link_pc   (link_pc_s),
    .pc        (pc_s),
    .busy      (busy_s),
    .retired   (retired_s)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] pc;
    logic [7:0] link;
    logic [7:0] nxt;
  } exp_t;

  exp_t sb[$];

  logic [7:0] mon_nxt  = '0;
  logic       mon_pend = 1'b0;

  // Commit monitor: every exec pulse must match the oldest outstanding entry.
  always @(negedge clk) begin
    exp_t e;
    if (mon_pend) begin
      check_eq("next_pc", {24'd0, pc}, {24'd0, mon_nxt});
      mon_pend = 1'b0;
    end
    if (exec_en === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("exec_unexpected", {31'd0, exec_en}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("exec_pc", {24'd0, pc}, {24'd0, e.pc});
        check_eq("link_pc", {24'd0, link_pc}, {24'd0, e.link});
        mon_nxt  = e.nxt;
        mon_pend = 1'b1;
      end
    end
  end

  function automatic logic [7:0] ref_next(input logic [7:0] p, input logic [1:0] b,
                                          input logic psel, input logic z,
                                          input logic [7:0] off, input logic [7:0] ra);
    logic [7:0] seq;
    seq = p + 8'd1;
    if (b == 2'b10) return ra;
    if (b == 2'b11) return seq + off;
    if (b == 2'b01 && (z != psel)) return seq + off;
    return seq;
  endfunction

  function automatic logic [16:0] mk(input logic [4:0] op, input logic [7:0] low);
    return {op, 4'h0, low};
  endfunction

  logic [7:0] model_pc = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction: fetch (with optional ack delay), decode, exec (with
  // optional data-memory stall), optionally dropping run during decode.
  task automatic do_instr(input logic [16:0] inst, input logic [1:0] b,
                          input logic p, input logic z, input logic [7:0] ra,
                          input int unsigned ack_dly, input int unsigned stall,
                          input logic drop_run);
    int unsigned w;
    int unsigned start;
    exp_t e;
    w = 0;
    while (bus.imem_req !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check_eq("fetch_req", {31'd0, bus.imem_req}, 32'd1);
    start = cyc;
    for (int unsigned k = 0; k < ack_dly; k++) begin
      check_eq("req_hold", {31'd0, bus.imem_req}, 32'd1);
      check_eq("addr_hold", {24'd0, bus.imem_addr}, {24'd0, model_pc});
      tick();
    end
    check_eq("fetch_addr", {24'd0, bus.imem_addr}, {24'd0, model_pc});
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = inst;
    bs        = b;
    ps        = p;
    zero      = z;
    reg_a     = ra;
    dmem_busy = (stall != 0);
    e.pc   = model_pc;
    e.link = model_pc + 8'd1;
    e.nxt  = ref_next(model_pc, b, p, z, inst[7:0], ra);
    sb.push_back(e);
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    if (drop_run) run = 1'b0;
    #1;
    check_eq("decode_ir", {15'd0, ir}, {15'd0, inst});
    check_eq("decode_exec_en", {31'd0, exec_en}, 32'd0);
    check_eq("req_drop", {31'd0, bus.imem_req}, 32'd0);
    tick();
    for (int unsigned s = 0; s < stall; s++) begin
      check_eq("stall_exec_en", {31'd0, exec_en}, 32'd0);
      check_eq("stall_pc", {24'd0, pc}, {24'd0, model_pc});
      tick();
    end
    dmem_busy = 1'b0;
    #1;
    check_eq("exec_en", {31'd0, exec_en}, 32'd1);
    check_eq("latency", cyc - start, ack_dly + 2 + stall);
    model_pc = e.nxt;
    tick();
    if (drop_run) begin
      check_eq("idle_busy", {31'd0, busy}, 32'd0);
      check_eq("idle_req", {31'd0, bus.imem_req}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    run            = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bs             = BS_INC;
    ps             = 1'b0;
    zero           = 1'b0;
    reg_a          = '0;
    dmem_busy      = 1'b0;
    repeat (3) tick();
    check_eq("rst_pc", {24'd0, pc}, 32'd0);
    check_eq("rst_ir", {15'd0, ir}, 32'd0);
    check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("rst_exec_en", {31'd0, exec_en}, 32'd0);
    check_eq("rst_retired", {16'd0, retired}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_no_run", {31'd0, busy}, 32'd0);

    run = 1'b1;
    do_instr(mk(OP_NOP, 8'h00), BS_INC, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0);
    do_instr(mk(OP_ADD, 8'h12), BS_INC, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0);
    do_instr(mk(OP_SUB, 8'h34), BS_INC, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0);
    check_eq("retired3", {16'd0, retired}, 32'd3);

    do_instr(mk(OP_JMP, 8'h00), BS_REG,  1'b0, 1'b0, 8'h10, 0, 0, 1'b0);
    do_instr(mk(OP_BRZ, 8'hFC), BS_COND, 1'b0, 1'b1, 8'h00, 0, 0, 1'b0);
    do_instr(mk(OP_JMP, 8'h00), BS_REG,  1'b0, 1'b0, 8'h10, 0, 0, 1'b0);
    do_instr(mk(OP_BRZ, 8'hFC), BS_COND, 1'b0, 1'b0, 8'h00, 1, 0, 1'b0);
    do_instr(mk(OP_BRN, 8'h05), BS_COND, 1'b1, 1'b0, 8'h00, 0, 0, 1'b0);
    do_instr(mk(OP_JMP, 8'h80), BS_JMP,  1'b0, 1'b0, 8'h00, 0, 0, 1'b0);
    do_instr(mk(OP_JMP, 8'h00), BS_REG,  1'b0, 1'b0, 8'hFF, 0, 0, 1'b0);
    do_instr(mk(OP_INC, 8'h00), BS_INC,  1'b0, 1'b0, 8'h00, 0, 0, 1'b0);
    do_instr(mk(OP_JMP, 8'h00), BS_REG,  1'b0, 1'b0, 8'hFF, 0, 0, 1'b0);
    do_instr(mk(OP_JML, 8'h00), BS_REG,  1'b0, 1'b0, 8'h42, 0, 0, 1'b0);
    do_instr(mk(OP_LD,  8'h00), BS_INC,  1'b0, 1'b0, 8'h00, 4, 2, 1'b0);
    do_instr(mk(OP_ST,  8'h07), BS_INC,  1'b0, 1'b0, 8'h00, 0, 1, 1'b1);

    repeat (3) tick();
    check_eq("hold_busy", {31'd0, busy}, 32'd0);
    check_eq("hold_pc", {24'd0, pc}, {24'd0, model_pc});
    check_eq("hold_ir", {15'd0, ir}, {15'd0, mk(OP_ST, 8'h07)});

    run = 1'b1;
    do_instr(mk(OP_ADI, 8'h01), BS_INC, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0);
    check_eq("retired16", {16'd0, retired}, 32'd16);
    check_eq("retired_sat", {29'd0, retired_s}, 32'd7);

    w_fetch: begin
      int unsigned w = 0;
      while (bus.imem_req !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      check_eq("pre_rst_req", {31'd0, bus.imem_req}, 32'd1);
    end
    rst_n          = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = mk(OP_XOR, 8'hAA);
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    rst_n          = 1'b1;
    run            = 1'b0;
    #1;
    check_eq("midrst_ir", {15'd0, ir}, 32'd0);
    check_eq("midrst_pc", {24'd0, pc}, 32'd0);
    check_eq("midrst_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_retired", {16'd0, retired}, 32'd0);
    check_eq("midrst_retired_sat", {29'd0, retired_s}, 32'd0);
    tick();
    check_eq("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
